// File: rtl/rf_wb_pkg.sv
// rtl/rf_wb_pkg.sv - shared constants and requester enum for the register-file writeback arbiter
package rf_wb_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;
   localparam int REG_ZERO = 0;

   typedef enum logic [1:0] {
      REQ_NONE = 2'd0,
      REQ_PIPE = 2'd1,
      REQ_MDU  = 2'd2
   } req_t;

endpackage

// File: rtl/wb_starve_ctr.sv
// rtl/wb_starve_ctr.sv - saturating mdu starvation counter and force flag (used with RF_WB_STARVE_GUARD_EN)
module wb_starve_ctr #(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic req_waiting_i,
   input  logic req_granted_i,
   output logic force_o
);
   import rf_wb_pkg::*;

   localparam int CNT_W = $clog2(LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             force_q, force_d;

   // force is raised for the cycle after the count reaches the limit and drops once mdu is taken
   always_comb begin
      cnt_d   = cnt_q;
      force_d = 1'b0;
      if (req_granted_i || !req_waiting_i) begin
         cnt_d = '0;
      end else if (cnt_q != LIMIT_C) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (req_waiting_i && (cnt_d == LIMIT_C)) begin
         force_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         force_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         force_q <= force_d;
      end
   end

   assign force_o = force_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - pipe/mdu arbiter for the register-file write port; optional RF_WB_STARVE_GUARD_EN
module rf_wb_arbiter #(
   parameter int DATA_W       = rf_wb_pkg::DATA_W,
   parameter int ADDR_W       = rf_wb_pkg::ADDR_W,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pipe_valid,
   input  logic [ADDR_W-1:0] pipe_sel,
   input  logic [DATA_W-1:0] pipe_din,
   output logic              pipe_ready,
   input  logic              mdu_valid,
   input  logic [ADDR_W-1:0] mdu_sel,
   input  logic [DATA_W-1:0] mdu_din,
   output logic              mdu_ready,
   output logic              writeEnable,
   output logic [ADDR_W-1:0] sel,
   output logic [DATA_W-1:0] Din,
   output logic              mdu_stall_pipe
);
   import rf_wb_pkg::*;

   logic              force_w;
   logic              gnt_pipe, gnt_mdu;
   req_t              grant_src;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] sel_q, sel_d;
   logic [DATA_W-1:0] din_q, din_d;

`ifdef RF_WB_STARVE_GUARD_EN
   wb_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve_ctr (
      .clk           (clk),
      .reset         (reset),
      .req_waiting_i (mdu_valid && !mdu_ready),
      .req_granted_i (gnt_mdu),
      .force_o       (force_w)
   );
`else
   // Without the guard mdu only gets through on pipe-idle cycles; this is constant 0.
   assign force_w = (STARVE_LIMIT < 0);
`endif

   assign pipe_ready     = !force_w;
   assign mdu_ready      = force_w || !pipe_valid;
   assign mdu_stall_pipe = force_w && pipe_valid;

   assign gnt_pipe = pipe_valid && pipe_ready;
   assign gnt_mdu  = mdu_valid && mdu_ready;

   always_comb begin
      grant_src = REQ_NONE;
      if (gnt_pipe) begin
         grant_src = REQ_PIPE;
      end else if (gnt_mdu) begin
         grant_src = REQ_MDU;
      end
   end

   // r0 writes complete the handshake but never raise the strobe
   always_comb begin
      we_d  = 1'b0;
      sel_d = sel_q;
      din_d = din_q;
      case (grant_src)
         REQ_PIPE: begin
            we_d  = (pipe_sel != ADDR_W'(REG_ZERO));
            sel_d = pipe_sel;
            din_d = pipe_din;
         end
         REQ_MDU: begin
            we_d  = (mdu_sel != ADDR_W'(REG_ZERO));
            sel_d = mdu_sel;
            din_d = mdu_din;
         end
         default: begin
            we_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         we_q  <= 1'b0;
         sel_q <= '0;
         din_q <= '0;
      end else begin
         we_q  <= we_d;
         sel_q <= sel_d;
         din_q <= din_d;
      end
   end

   assign writeEnable = we_q;
   assign sel         = sel_q;
   assign Din         = din_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter (table vectors, corner sequences, random vs model)
module tb_rf_wb_arbiter;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int LIM = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          pipe_valid;
   logic [AW-1:0] pipe_sel;
   logic [DW-1:0] pipe_din;
   logic          pipe_ready;
   logic          mdu_valid;
   logic [AW-1:0] mdu_sel;
   logic [DW-1:0] mdu_din;
   logic          mdu_ready;
   logic          writeEnable;
   logic [AW-1:0] sel;
   logic [DW-1:0] Din;
   logic          mdu_stall_pipe;

   always #5 clk = ~clk;

   rf_wb_arbiter #(
      .DATA_W       (DW),
      .ADDR_W       (AW),
      .STARVE_LIMIT (LIM)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .pipe_valid     (pipe_valid),
      .pipe_sel       (pipe_sel),
      .pipe_din       (pipe_din),
      .pipe_ready     (pipe_ready),
      .mdu_valid      (mdu_valid),
      .mdu_sel        (mdu_sel),
      .mdu_din        (mdu_din),
      .mdu_ready      (mdu_ready),
      .writeEnable    (writeEnable),
      .sel            (sel),
      .Din            (Din),
      .mdu_stall_pipe (mdu_stall_pipe)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: expected registered outputs, mdu denial streak, pending commits
   logic          m_we   = 1'b0;
   logic [AW-1:0] m_sel  = '0;
   logic [DW-1:0] m_din  = '0;
   int            m_wait = 0;
   logic [AW+DW-1:0] exp_q[$];

   task automatic step(input logic rst, input logic pv, input logic [AW-1:0] ps, input logic [DW-1:0] pd,
                       input logic mv, input logic [AW-1:0] ms, input logic [DW-1:0] md, output logic gm_o);
      logic f, epr, emr, gp, gm;
      logic [AW+DW-1:0] e;
      @(negedge clk);
      reset = rst; pipe_valid = pv; pipe_sel = ps; pipe_din = pd;
      mdu_valid = mv; mdu_sel = ms; mdu_din = md;
      #1;
`ifdef RF_WB_STARVE_GUARD_EN
      f = (m_wait == LIM);
`else
      f = 1'b0;
`endif
      epr = !f;
      emr = f || !pv;
      check("pipe_ready", pipe_ready, epr);
      check("mdu_ready", mdu_ready, emr);
      check("mdu_stall_pipe", mdu_stall_pipe, f && pv);
      check("writeEnable", writeEnable, m_we);
      check("sel", sel, m_sel);
      check("Din", Din, m_din);
      if (writeEnable === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL commit_spurious: got sel=%0d din=%0h expected no write", sel, Din);
         end else begin
            e = exp_q.pop_front();
            check("commit_order", {sel, Din}, e);
         end
      end
      gp = pv && epr;
      gm = mv && emr && !gp;
      gm_o = gm && !rst;
      if (rst) begin
         m_we = 1'b0; m_sel = '0; m_din = '0; m_wait = 0;
         exp_q.delete();
      end else begin
         if (gp) begin
            m_we = (ps != 0); m_sel = ps; m_din = pd;
         end else if (gm) begin
            m_we = (ms != 0); m_sel = ms; m_din = md;
         end else begin
            m_we = 1'b0;
         end
         if (m_we) exp_q.push_back({m_sel, m_din});
         m_wait = (mv && !emr) ? ((m_wait < LIM) ? m_wait + 1 : LIM) : 0;
      end
   endtask

   typedef struct {
      logic          rst, pv, mv;
      logic [AW-1:0] ps, ms;
      logic [DW-1:0] pd, md;
      logic          epr, emr, ewe;
      logic [AW-1:0] esel;
      logic [DW-1:0] edin;
   } vec_t;

   function automatic vec_t mk(logic rst, logic pv, logic [AW-1:0] ps, logic [DW-1:0] pd,
                               logic mv, logic [AW-1:0] ms, logic [DW-1:0] md,
                               logic epr, logic emr, logic ewe, logic [AW-1:0] esel, logic [DW-1:0] edin);
      vec_t v;
      v.rst = rst; v.pv = pv; v.ps = ps; v.pd = pd; v.mv = mv; v.ms = ms; v.md = md;
      v.epr = epr; v.emr = emr; v.ewe = ewe; v.esel = esel; v.edin = edin;
      return v;
   endfunction

   vec_t tbl[14];

   initial begin
      logic g;
      logic r_pv, r_mv, pend;
      logic [AW-1:0] hs;
      logic [DW-1:0] hd;

      reset = 1'b1; pipe_valid = 1'b1; pipe_sel = 5'd7; pipe_din = 32'h1;
      mdu_valid = 1'b0; mdu_sel = '0; mdu_din = '0;
      @(posedge clk);

      tbl[0]  = mk(1, 1, 7, 32'h1,        0, 0, 0,     1, 0, 0, 0, 32'h0);
      tbl[1]  = mk(1, 1, 7, 32'h1,        0, 0, 0,     1, 0, 0, 0, 32'h0);
      tbl[2]  = mk(0, 0, 0, 32'h0,        0, 0, 0,     1, 1, 0, 0, 32'h0);
      tbl[3]  = mk(0, 1, 7, 32'hDEADBEEF, 0, 0, 0,     1, 0, 0, 0, 32'h0);
      tbl[4]  = mk(0, 0, 0, 32'h0,        0, 0, 0,     1, 1, 1, 7, 32'hDEADBEEF);
      tbl[5]  = mk(0, 1, 3, 32'h11,       1, 3, 32'h22, 1, 0, 0, 7, 32'hDEADBEEF);
      tbl[6]  = mk(0, 0, 0, 32'h0,        1, 3, 32'h22, 1, 1, 1, 3, 32'h11);
      tbl[7]  = mk(0, 0, 0, 32'h0,        0, 0, 0,     1, 1, 1, 3, 32'h22);
      tbl[8]  = mk(0, 1, 0, 32'h5,        0, 0, 0,     1, 0, 0, 3, 32'h22);
      tbl[9]  = mk(0, 0, 0, 32'h0,        0, 0, 0,     1, 1, 0, 0, 32'h5);
      tbl[10] = mk(0, 1, 9, 32'h99,       0, 0, 0,     1, 0, 0, 0, 32'h5);
      tbl[11] = mk(1, 0, 0, 32'h0,        1, 4, 32'h44, 1, 1, 1, 9, 32'h99);
      tbl[12] = mk(0, 0, 0, 32'h0,        1, 4, 32'h44, 1, 1, 0, 0, 32'h0);
      tbl[13] = mk(0, 0, 0, 32'h0,        0, 0, 0,     1, 1, 1, 4, 32'h44);

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].rst, tbl[i].pv, tbl[i].ps, tbl[i].pd, tbl[i].mv, tbl[i].ms, tbl[i].md, g);
         check($sformatf("tbl%0d_pipe_ready", i), pipe_ready, tbl[i].epr);
         check($sformatf("tbl%0d_mdu_ready", i), mdu_ready, tbl[i].emr);
         check($sformatf("tbl%0d_we", i), writeEnable, tbl[i].ewe);
         check($sformatf("tbl%0d_sel", i), sel, tbl[i].esel);
         check($sformatf("tbl%0d_din", i), Din, tbl[i].edin);
      end

      // pipe held busy while mdu waits on r9
      step(1, 0, 0, 0, 0, 0, 0, g);
`ifdef RF_WB_STARVE_GUARD_EN
      for (int k = 0; k < LIM; k++) begin
         step(0, 1, 5'(k + 1), 32'(k), 1, 9, 32'hABCD, g);
         check("starve_mdu_ready_low", mdu_ready, 1'b0);
         check("starve_stall_low", mdu_stall_pipe, 1'b0);
      end
      step(0, 1, 5'd20, 32'h20, 1, 9, 32'hABCD, g);
      check("forced_mdu_ready", mdu_ready, 1'b1);
      check("forced_pipe_ready", pipe_ready, 1'b0);
      check("forced_stall", mdu_stall_pipe, 1'b1);
      step(0, 1, 5'd21, 32'h21, 0, 0, 0, g);
      check("forced_commit_we", writeEnable, 1'b1);
      check("forced_commit_sel", sel, 5'd9);
      check("forced_commit_din", Din, 32'hABCD);
      check("after_force_pipe_ready", pipe_ready, 1'b1);
`else
      for (int k = 0; k < 8; k++) begin
         step(0, 1, 5'(k + 1), 32'(k), 1, 9, 32'hABCD, g);
         check("busy_mdu_ready_low", mdu_ready, 1'b0);
         check("busy_stall_low", mdu_stall_pipe, 1'b0);
      end
      step(0, 0, 0, 0, 1, 9, 32'hABCD, g);
      check("idle_mdu_ready", mdu_ready, 1'b1);
      step(0, 0, 0, 0, 0, 0, 0, g);
      check("idle_commit_sel", sel, 5'd9);
      check("idle_commit_din", Din, 32'hABCD);
`endif

      // random mixed traffic; mdu holds its request until accepted
      pend = 1'b0; r_mv = 1'b0; hs = '0; hd = '0;
      for (int i = 0; i < 96; i++) begin
         r_pv = ($urandom_range(0, 3) != 0);
         if (!pend) begin
            r_mv = 1'($urandom_range(0, 1));
            hs   = 5'($urandom_range(0, 31));
            hd   = $urandom;
         end
         step(0, r_pv, 5'($urandom_range(0, 31)), $urandom, r_mv, hs, hd, g);
         pend = r_mv && !g;
      end
      step(0, 0, 0, 0, pend, hs, hd, g);
      step(0, 0, 0, 0, 0, 0, 0, g);
      step(0, 0, 0, 0, 0, 0, 0, g);
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
